// File: rtl/mem_responder.sv
// Word-memory responder for the VeriRISC bus: one access per rd/wr edge, read data WAIT_STATES+1 clocks after the request.
// Holds ready low through the wait and response cycles (only when WAIT_STATES>0); new edges arriving while busy are dropped.
module mem_responder #(
  parameter int AWIDTH      = 5,
  parameter int DWIDTH      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic              data_e,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_valid,
  output logic              ready,
  output logic              err,
  input  logic              ld_en,
  input  logic [AWIDTH-1:0] ld_addr,
  input  logic [DWIDTH-1:0] ld_data
);

  localparam int         DEPTH    = 1 << AWIDTH;
  localparam logic       HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic              rd_q, wr_q;
  logic [2:0]        cnt, cnt_nx;
  logic [AWIDTH-1:0] a_lat, a_lat_nx;
  logic [DWIDTH-1:0] d_lat, d_lat_nx;
  logic              is_wr, is_wr_nx;
  logic              err_nx;
  logic              ld_do;
  logic              rd_req, wr_req;
  logic [DWIDTH-1:0] mem [DEPTH];

  assign rd_req = rd & ~rd_q;
  assign wr_req = wr & ~wr_q;
  assign ready  = ~((state == WAIT) | ((state == RESP) & HAS_WAIT));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    a_lat_nx = a_lat;
    d_lat_nx = d_lat;
    is_wr_nx = is_wr;
    err_nx   = 1'b0;
    ld_do    = 1'b0;
    case (state)
      IDLE: begin
        ld_do = ld_en;
        // a program load wins over any coincident bus request
        if (ld_en) begin
          err_nx = rd_req | wr_req;
        end else if (rd_req & wr_req) begin
          err_nx = 1'b1;
        end else if (wr_req & ~data_e) begin
          err_nx = 1'b1;
        end else if (rd_req | wr_req) begin
          a_lat_nx = addr;
          d_lat_nx = data_in;
          is_wr_nx = wr_req;
          if (HAS_WAIT) begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end else begin
            state_nx = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == 3'd0) state_nx = RESP;
        else             cnt_nx   = cnt - 3'd1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      cnt        <= 3'd0;
      a_lat      <= '0;
      d_lat      <= '0;
      is_wr      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      rd_q       <= rd;
      wr_q       <= wr;
      cnt        <= cnt_nx;
      a_lat      <= a_lat_nx;
      d_lat      <= d_lat_nx;
      is_wr      <= is_wr_nx;
      err        <= err_nx;
      data_valid <= (state == RESP) & ~is_wr;
      if ((state == RESP) & ~is_wr) data_out <= mem[a_lat];
    end
  end

  // no reset on the array: contents survive rst, and reset forces IDLE so no write is pending
  always_ff @(posedge clk) begin
    if ((state == RESP) & is_wr) mem[a_lat]   <= d_lat;
    else if (ld_do)              mem[ld_addr] <= ld_data;
  end

endmodule
